// File: rtl/calculator_uart_reporter.sv
// Serial reporter: on a rising edge of IN_send, captures the result word and sign and
// transmits them as an uppercase ASCII hex line (optional '-', 8 digits, CR, LF) over UART 8N1.
module calculator_uart_reporter #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IN_answer,
    input  logic        IN_is_negative,
    input  logic        IN_send,
    output logic        OUT_tx,
    output logic        OUT_busy,
    output logic        OUT_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [3:0]        byte_idx;
    logic              send_q;
    logic              tx;
    logic              busy;
    logic              done;
    logic [31:0]       mag;
    logic              neg;
    logic              request;
    logic              baud_end;
    logic              capture;
    logic [3:0]        last_idx;
    logic [7:0]        cur_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

    // Byte at position idx of the message; the '-' shifts digit positions by one.
    function automatic logic [7:0] msg_byte(input logic [31:0] m, input logic s,
                                            input logic [3:0] idx);
        logic [3:0]  d;
        logic [31:0] sh;
        d  = idx - {3'b000, s};
        sh = m << {d[2:0], 2'b00};
        if (s && idx == 4'd0)
            return 8'h2D;
        else if (d < 4'd8)
            return hex_char(sh[31:28]);
        else if (d == 4'd8)
            return 8'h0D;
        return 8'h0A;
    endfunction

    assign request  = IN_send & ~send_q;
    assign baud_end = (baud_cnt == BAUD_LAST);
    assign capture  = (state == IDLE) && request;
    assign last_idx = neg ? 4'd10 : 4'd9;
    assign cur_byte = msg_byte(mag, neg, byte_idx);

    assign OUT_tx   = tx;
    assign OUT_busy = busy;
    assign OUT_done = done;

    // Captured message payload; only read while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mag <= IN_is_negative ? (~IN_answer + 32'd1) : IN_answer;
            neg <= IN_is_negative;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            send_q   <= 1'b1;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            send_q <= IN_send;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        byte_idx <= 4'd0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        tx       <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == last_idx) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            byte_idx <= 4'd0;
                        end else begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= START;
                            tx       <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calculator_uart_reporter.sv
// Randomized self-checking bench for calculator_uart_reporter against a string-level message model.
module tb_calculator_uart_reporter;

    localparam int CPB = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] answer;
    logic        is_neg;
    logic        send;
    logic        tx;
    logic        busy;
    logic        done;

    int n_checks;
    int n_pass;
    logic [7:0] exp_q[$];

    calculator_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .IN_answer(answer),
        .IN_is_negative(is_neg),
        .IN_send(send),
        .OUT_tx(tx),
        .OUT_busy(busy),
        .OUT_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference message: text of the magnitude in hex, sign prefix, CR LF.
    function automatic void build_expected(input logic [31:0] ans, input logic neg);
        logic [31:0] m;
        int nib;
        exp_q.delete();
        m = neg ? (32'd0 - ans) : ans;
        if (neg) exp_q.push_back("-");
        for (int i = 7; i >= 0; i--) begin
            nib = int'((m >> (4 * i)) & 32'hF);
            if (nib < 10) exp_q.push_back(8'("0" + nib));
            else          exp_q.push_back(8'("A" + nib - 10));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // mode 0: plain pulse; 1: change inputs and re-request mid-message; 2: hold IN_send 1000 cycles
    task automatic send_msg(input logic [31:0] ans, input logic neg, input int mode);
        int total, bit_err, busy_cnt, done_cnt, pos, held;
        logic [7:0] b, dec;
        logic expbit;
        build_expected(ans, neg);
        total = exp_q.size() * 10 * CPB;
        bit_err = 0; busy_cnt = 0; done_cnt = 0; dec = 8'h00;
        @(negedge clk);
        answer = ans; is_neg = neg; send = 1'b1;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            if (c == 0 && mode != 2) send = 1'b0;
            if (mode == 1 && c == total / 2) begin
                answer = ~ans; is_neg = ~neg; send = 1'b1;
            end
            if (mode == 1 && c == total / 2 + 1) send = 1'b0;
            b   = exp_q[c / (10 * CPB)];
            pos = (c % (10 * CPB)) / CPB;
            expbit = (pos == 0) ? 1'b0 : (pos == 9) ? 1'b1 : b[pos - 1];
            if (tx !== expbit) bit_err++;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if ((c % CPB) == CPB / 2) begin
                if (pos >= 1 && pos <= 8) dec[pos - 1] = tx;
                if (pos == 9) check("byte", {24'h0, dec}, {24'h0, b});
            end
        end
        check("bit_timing", bit_err, 0);
        check("busy_cycles", busy_cnt, total);
        check("done_early", done_cnt, 0);
        @(negedge clk);
        check("done_pulse", {31'h0, done}, 1);
        check("busy_end", {31'h0, busy}, 0);
        check("tx_idle", {31'h0, tx}, 1);
        if (mode == 2) begin
            held = 0;
            for (int c = total + 2; c < 1000; c++) begin
                @(negedge clk);
                if (busy === 1'b1 || done === 1'b1) held++;
            end
            check("held_single", held, 0);
            send = 1'b0;
        end
        @(negedge clk);
        check("done_width", {31'h0, done}, 0);
        check("no_requeue", {31'h0, busy}, 0);
    endtask

    initial begin
        int busy_seen;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; send = 1'b1; answer = 32'h0; is_neg = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", {31'h0, tx}, 1);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) busy_seen++;
        end
        check("held_through_reset", busy_seen, 0);
        send = 1'b0;
        @(negedge clk);

        send_msg(32'h0000002A, 1'b0, 0);
        send_msg(32'hFFFFFFF6, 1'b1, 0);
        send_msg(32'h80000000, 1'b1, 0);
        send_msg(32'hFFFFFFFF, 1'b0, 0);
        send_msg(32'h00000000, 1'b1, 0);
        send_msg(32'h12345678, 1'b0, 1);
        send_msg(32'hABCDEF01, 1'b1, 2);
        for (int i = 0; i < 6; i++)
            send_msg($urandom, 1'($urandom_range(0, 1)), 0);

        // Abort partway through byte 5, then a fresh message must be complete.
        @(negedge clk);
        answer = 32'hDEADBEEF; is_neg = 1'b0; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5 * 10 * CPB + 10) @(negedge clk);
        check("abort_busy_before", {31'h0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", {31'h0, tx}, 1);
        check("abort_busy", {31'h0, busy}, 0);
        busy_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) busy_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) busy_seen++;
        end
        check("abort_no_done", busy_seen, 0);
        send_msg(32'hC0FFEE00, 1'b1, 0);
        send_msg($urandom, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
